// File: rtl/pll_drp_pkg.sv
// pll_drp_pkg: states, DRP register map and counter encoding for the PLL reconfiguration sequencer
package pll_drp_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RST, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RELEASE, S_LOCK, S_DONE, S_ERR
  } state_e;
  localparam logic [6:0] ADDR_FB1 = 7'h14;
  localparam logic [6:0] ADDR_FB2 = 7'h15;
  localparam logic [6:0] ADDR_CO1 = 7'h08;
  localparam logic [6:0] ADDR_CO2 = 7'h09;
  localparam logic [15:0] KEEP1 = 16'h1000;
  localparam logic [15:0] KEEP2 = 16'hFF00;
  localparam logic [6:0] MULT_MIN = 7'd2;
  localparam logic [6:0] MULT_MAX = 7'd64;
  localparam logic [7:0] DIV_MIN = 8'd1;
  localparam logic [7:0] DIV_MAX = 8'd128;
  typedef struct packed {
    logic [5:0] hi;
    logic [5:0] lo;
    logic       edg;
    logic       nocount;
  } cnt_t;
  function automatic cnt_t cnt_enc(input logic [7:0] d);
    logic [7:0] h;
    logic [7:0] l;
    h = d >> 1;
    l = d - h;
    cnt_enc.hi = (d == 8'd1) ? 6'd1 : h[5:0];
    cnt_enc.lo = (d == 8'd1) ? 6'd1 : l[5:0];
    cnt_enc.edg = (d == 8'd1) ? 1'b0 : d[0];
    cnt_enc.nocount = d == 8'd1;
  endfunction
  function automatic logic [6:0] drp_addr(input logic [1:0] i);
    drp_addr = i == 2'd0 ? ADDR_FB1 : i == 2'd1 ? ADDR_FB2 : i == 2'd2 ? ADDR_CO1 : ADDR_CO2;
  endfunction
  function automatic logic [15:0] merge(input logic [1:0] i, input logic [15:0] rd,
                                        input logic [6:0] mult, input logic [7:0] div0);
    cnt_t c;
    c = cnt_enc(i[1] ? div0 : {1'b0, mult});
    merge = i[0] ? (rd & KEEP2) | {8'h00, c.edg, c.nocount, 6'h00} : (rd & KEEP1) | {4'h0, c.hi, c.lo};
  endfunction
endpackage

// File: rtl/pll_drp_reconfig_sync.sv
// pll_drp_reconfig_sync: multi-flop synchroniser for an asynchronous level
module pll_drp_reconfig_sync #(
  parameter int Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [Stages-1:0] r_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_q <= '0;
    else r_q <= Stages'({r_q, d_i});
  assign q_o = r_q[Stages-1];
endmodule

// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig: reprograms PLL feedback and CLKOUT0 counters over DRP, then waits for relock
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int DrpTimeout     = 64,
  parameter int LockTimeout    = 65535,
  parameter int LockSyncStages = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  mult_i,
  input  logic [7:0]  div0_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [6:0]  drp_daddr_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  output logic        pll_rst_o,
  input  logic        pll_locked_i
);
  localparam int CW = $clog2((DrpTimeout > LockTimeout ? DrpTimeout : LockTimeout) + 1);
  state_e r_state, w_next;
  logic [1:0] r_idx, w_idx;
  logic [CW-1:0] r_cnt;
  logic [6:0] r_mult;
  logic [7:0] r_div;
  logic w_locked, w_legal, w_drp_to, w_lock_to;
  logic r_ready, r_busy, r_done, r_err, r_den, r_dwe, r_pll_rst;
  logic [6:0] r_daddr;
  logic [15:0] r_di;
  pll_drp_reconfig_sync #(.Stages(LockSyncStages)) u_lock_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pll_locked_i),
    .q_o   (w_locked)
  );
  assign w_legal = r_mult >= MULT_MIN && r_mult <= MULT_MAX && r_div >= DIV_MIN && r_div <= DIV_MAX;
  assign w_drp_to = r_cnt == CW'(DrpTimeout - 1);
  assign w_lock_to = r_cnt == CW'(LockTimeout - 1);
  assign w_idx = r_state == S_RST ? 2'd0 : (r_state == S_WR_WAIT && drp_drdy_i) ? r_idx + 2'd1 : r_idx;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (req_valid_i && r_ready) ? S_CHECK : S_IDLE;
      S_CHECK:   w_next = w_legal ? S_RST : S_ERR;
      S_RST:     w_next = S_RD_REQ;
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = drp_drdy_i ? S_WR_REQ : w_drp_to ? S_ERR : S_RD_WAIT;
      S_WR_REQ:  w_next = S_WR_WAIT;
      S_WR_WAIT: w_next = drp_drdy_i ? (r_idx == 2'd3 ? S_RELEASE : S_RD_REQ) : w_drp_to ? S_ERR : S_WR_WAIT;
      S_RELEASE: w_next = S_LOCK;
      S_LOCK:    w_next = w_locked ? S_DONE : w_lock_to ? S_ERR : S_LOCK;
      default:   w_next = S_IDLE;
    endcase
  end
  // Outputs are registered decodes of the next state so reset forces every one of them low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_mult <= '0;
      r_div <= '0;
      r_ready <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_den <= 1'b0;
      r_dwe <= 1'b0;
      r_pll_rst <= 1'b0;
      r_daddr <= '0;
      r_di <= '0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx;
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if (req_valid_i && r_ready) begin
        r_mult <= mult_i;
        r_div <= div0_i;
      end
      r_ready <= w_next == S_IDLE;
      r_busy <= w_next != S_IDLE;
      r_done <= w_next == S_DONE;
      r_err <= w_next == S_ERR;
      r_den <= w_next == S_RD_REQ || w_next == S_WR_REQ;
      r_dwe <= w_next == S_WR_REQ;
      r_pll_rst <= w_next inside {S_RST, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT};
      r_daddr <= (w_next == S_RD_REQ || w_next == S_WR_REQ) ? drp_addr(w_idx) : '0;
      r_di <= w_next == S_WR_REQ ? merge(r_idx, drp_do_i, r_mult, r_div) : '0;
    end
  end
  assign req_ready_o = r_ready;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o = r_err;
  assign drp_den_o = r_den;
  assign drp_dwe_o = r_dwe;
  assign drp_daddr_o = r_daddr;
  assign drp_di_o = r_di;
  assign pll_rst_o = r_pll_rst;
endmodule

// File: tb/tb_pll_drp_reconfig.sv
// tb_pll_drp_reconfig: scoreboard bench with DRP/PLL models and a reference model of the register words
module tb_pll_drp_reconfig;
  localparam int DRP_TO = 64;
  localparam int LOCK_TO = 100;
  typedef struct {int addr; int data;} wr_t;
  logic clk = 0, rst_ni = 0, req_valid_i = 0, drp_drdy_i = 0, pll_locked_i = 0;
  logic [6:0] mult_i = 0;
  logic [7:0] div0_i = 0;
  logic [15:0] drp_do_i = 0;
  logic req_ready_o, busy_o, done_o, err_o, drp_den_o, drp_dwe_o, pll_rst_o;
  logic [6:0] drp_daddr_o;
  logic [15:0] drp_di_o;
  int checks = 0, failures = 0;
  wr_t exp_wr[$];
  int exp_out[$];
  int rb[128];
  int no_rsp = 0, slow = 0, lock_en = 1, lock_dly = 5;
  pll_drp_reconfig #(.DrpTimeout(DRP_TO), .LockTimeout(LOCK_TO), .LockSyncStages(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .mult_i(mult_i), .div0_i(div0_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .drp_daddr_o(drp_daddr_o), .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o), .drp_di_o(drp_di_o),
    .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i), .pll_rst_o(pll_rst_o), .pll_locked_i(pll_locked_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {2'b0, req_ready_o, busy_o, done_o, err_o, drp_den_o, drp_dwe_o, pll_rst_o, drp_daddr_o, drp_di_o};
  endfunction
  function automatic int w1(input int d, input int rd);
    int hi, lo;
    hi = d == 1 ? 1 : d / 2;
    lo = d == 1 ? 1 : d - hi;
    return (rd & 'h1000) | ((hi % 64) << 6) | (lo % 64);
  endfunction
  function automatic int w2(input int d, input int rd);
    return (rd & 'hFF00) | (d == 1 ? 64 : (d % 2) * 128);
  endfunction
  task automatic push_wr(input int a, input int d);
    exp_wr.push_back('{a, d});
  endtask
  task automatic push_model(input int m, input int d);
    push_wr('h14, w1(m, rb['h14]));
    push_wr('h15, w2(m, rb['h15]));
    push_wr('h08, w1(d, rb['h08]));
    push_wr('h09, w2(d, rb['h09]));
  endtask
  task automatic set_rb(input int v);
    rb['h14] = v; rb['h15] = v; rb['h08] = v; rb['h09] = v;
  endtask
  task automatic rand_rb();
    rb['h14] = $urandom_range(0, 65535); rb['h15] = $urandom_range(0, 65535);
    rb['h08] = $urandom_range(0, 65535); rb['h09] = $urandom_range(0, 65535);
  endtask
  task automatic drive(input int m, input int d);
    int n = 0;
    while (!req_ready_o && n < 500) begin @(negedge clk); n++; end
    chk("ready_wait", req_ready_o, 1);
    mult_i = 7'(m);
    div0_i = 8'(d);
    req_valid_i = 1;
  endtask
  task automatic issue(input int m, input int d);
    drive(m, d);
    @(negedge clk);
    req_valid_i = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 3000) begin @(negedge clk); n++; end
    chk("idle_reached", req_ready_o, 1);
    chk("sb_drained", exp_wr.size() + exp_out.size(), 0);
  endtask
  task automatic legal_txn(input int m, input int d);
    push_model(m, d);
    exp_out.push_back(1);
    issue(m, d);
    wait_idle();
  endtask
  task automatic illegal_req(input int m, input int d);
    int e = -1, n_den = 0, n_rst = 0;
    exp_out.push_back(0);
    drive(m, d);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid_i = 0;
      if (err_o && e < 0) e = k;
      n_den += int'(drp_den_o);
      n_rst += int'(pll_rst_o);
    end
    chk("illegal_err_lat", e, 2);
    chk("illegal_no_den", n_den, 0);
    chk("illegal_no_pll_rst", n_rst, 0);
    wait_idle();
  endtask
  initial begin
    int pend = 0;
    logic outst = 0;
    logic [6:0] addr_q = 0;
    forever begin
      @(posedge clk);
      #1;
      drp_drdy_i = 0;
      if (!rst_ni || !busy_o) begin
        pend = 0;
        outst = 0;
        if (rst_ni && $urandom_range(0, 7) == 0) drp_drdy_i = 1;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin drp_drdy_i = 1; drp_do_i = 16'(rb[addr_q]); outst = 0; end
        end
        if (drp_den_o) begin
          chk("den_while_outstanding", outst, 0);
          outst = 1;
          addr_q = drp_daddr_o;
          pend = no_rsp ? 0 : slow ? 6 : $urandom_range(1, 3);
        end
      end
    end
  end
  initial begin
    int lc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_ni || pll_rst_o || !lock_en) begin pll_locked_i = 0; lc = 0; end
      else if (lc < lock_dly) lc++;
      else pll_locked_i = 1;
    end
  end
  always @(negedge clk) begin
    wr_t w;
    int o;
    if (rst_ni) begin
      if (drp_den_o && !drp_dwe_o && exp_wr.size() > 0) chk("rd_addr", drp_daddr_o, exp_wr[0].addr);
      if (drp_den_o && drp_dwe_o) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual addr=%h data=%h required none", drp_daddr_o, drp_di_o);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", drp_daddr_o, w.addr);
          chk("wr_data", drp_di_o, w.data);
          chk("wr_pll_rst", pll_rst_o, 1);
        end
      end
      if (done_o || err_o) begin
        chk("done_err_excl", done_o & err_o, 0);
        if (exp_out.size() == 0) begin
          checks++; failures++;
          $display("FAIL outcome_unexpected actual done=%b err=%b required none", done_o, err_o);
        end else begin
          o = exp_out.pop_front();
          chk("outcome_done", done_o, o);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int kd, ke, r, e, nw, busy_acc, prev;
    for (int i = 0; i < 128; i++) rb[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", outs(), 0);
    rst_ni = 1;
    @(negedge clk);
    chk("ready_after_rst", req_ready_o, 1);
    chk("busy_after_rst", busy_o, 0);
    set_rb('hFFFF);
    push_wr('h14, 'h1514); push_wr('h15, 'hFF00); push_wr('h08, 'h130D); push_wr('h09, 'hFF80);
    exp_out.push_back(1);
    issue(40, 25);
    wait_idle();
    set_rb(0);
    push_wr('h14, 'h0041); push_wr('h15, 'h0000); push_wr('h08, 'h0041); push_wr('h09, 'h0040);
    exp_out.push_back(1);
    issue(2, 1);
    wait_idle();
    rand_rb();
    legal_txn(64, 128);
    illegal_req(65, 25);
    illegal_req(40, 0);
    illegal_req(1, 129);
    for (int t = 0; t < 10; t++) begin
      int m, d;
      m = $urandom_range(2, 64);
      d = $urandom_range(1, 128);
      lock_dly = $urandom_range(1, 20);
      rand_rb();
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) m = $urandom_range(65, 127);
        else d = $urandom_range(129, 255);
        illegal_req(m, d);
      end else legal_txn(m, d);
    end
    no_rsp = 1;
    exp_out.push_back(0);
    drive(30, 7);
    kd = -1; ke = -1;
    for (int k = 0; k < 300 && ke < 0; k++) begin
      @(negedge clk);
      req_valid_i = 0;
      if (drp_den_o && kd < 0) kd = k;
      if (err_o) begin ke = k; chk("drp_to_pll_rst_low", pll_rst_o, 0); end
    end
    chk("drp_to_lat", ke - kd, DRP_TO + 1);
    wait_idle();
    no_rsp = 0;
    lock_en = 0;
    rand_rb();
    push_model(12, 3);
    exp_out.push_back(0);
    drive(12, 3);
    r = -1; e = -1; busy_acc = 0; prev = 0;
    for (int k = 0; k < 500 && e < 0; k++) begin
      @(negedge clk);
      if (k == 0) req_valid_i = 0;
      if (prev == 1 && pll_rst_o == 0) r = k;
      prev = int'(pll_rst_o);
      if (r >= 0 && k == r + 10) begin mult_i = 50; div0_i = 5; req_valid_i = 1; end
      if (err_o) begin e = k; req_valid_i = 0; end
      else if (req_valid_i) busy_acc |= int'(req_ready_o);
    end
    checks++;
    if (r < 0 || e - r < LOCK_TO || e - r > LOCK_TO + 2) begin
      failures++;
      $display("FAIL lock_to_lat actual=%0d required=%0d..%0d", e - r, LOCK_TO, LOCK_TO + 2);
    end
    chk("busy_not_ready", busy_acc, 0);
    repeat (3) @(negedge clk);
    chk("second_req_ignored", busy_o, 0);
    chk("lock_to_drained", exp_wr.size() + exp_out.size(), 0);
    lock_en = 1;
    slow = 1;
    rand_rb();
    push_model(20, 9);
    exp_out.push_back(1);
    issue(20, 9);
    nw = 0;
    for (int k = 0; k < 300 && nw < 3; k++) begin
      @(negedge clk);
      if (drp_den_o && drp_dwe_o) nw++;
    end
    @(negedge clk);
    chk("pre_rst_pll_rst", pll_rst_o, 1);
    #2 rst_ni = 0;
    #1 chk("async_rst_outputs", outs(), 0);
    exp_wr.delete();
    exp_out.delete();
    slow = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
    rand_rb();
    legal_txn(33, 17);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
